// File: rtl/turbo_out_pkg.sv
`default_nettype none
// ============================================================================
// turbo_out_pkg : shared states, mode codes and sizing helpers for the turbo
//                 encoder output rate-matching buffer.
// Revision      : 1.0
// ============================================================================
package turbo_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    localparam logic MODE_NORMAL = 1'b0;
    localparam logic MODE_TERM   = 1'b1;

    localparam int BITS_NORMAL = 3;
    localparam int BITS_TERM   = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_ring_store.sv
`default_nettype none
// ============================================================================
// bit_ring_store : DEPTH-bit circular store, 4-bit scattered write and an
//                  OUT_LANES-bit contiguous read that wraps modulo DEPTH.
// Revision       : 1.0
// ============================================================================
module bit_ring_store #(
    parameter int DEPTH     = 32,
    parameter int OUT_LANES = 2,
    parameter int PW        = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4*PW-1:0]      wr_addr_i,
    input  logic [3:0]           wr_en_i,
    input  logic [3:0]           wr_data_i,
    input  logic [PW-1:0]        rd_addr_i,
    output logic [OUT_LANES-1:0] rd_data_o
);

    logic [DEPTH-1:0] mem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (wr_en_i[j]) begin
                    mem_q[wr_addr_i[j*PW +: PW]] <= wr_data_i[j];
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < OUT_LANES; i++) begin
            rd_data_o[i] = mem_q[rd_addr_i + PW'(i)];
        end
    end

endmodule
`default_nettype wire

// File: rtl/turbo_out_buffer.sv
`default_nettype none
// ============================================================================
// turbo_out_buffer : packs encoder symbols (tail symbols in termination order)
//                    into a bit ring and streams held OUT_LANES-bit words.
// Revision         : 1.0
// ============================================================================
module turbo_out_buffer
    import turbo_out_pkg::*;
#(
    parameter int IN_W      = 4,
    parameter int OUT_LANES = 2,
    parameter int DEPTH     = 32,
    parameter int TERM_SYMS = 3,
    parameter int HOLD      = 8,
    parameter int START_LVL = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [IN_W-1:0]      in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [OUT_LANES-1:0] out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 drop
);

    localparam int PW = ptr_w(DEPTH);
    localparam int FW = PW + 1;
    localparam int KW = $clog2(TERM_SYMS) + 1;
    localparam int HW = $clog2(HOLD) + 1;

    localparam logic [FW-1:0] DEPTH_F   = FW'(DEPTH);
    localparam logic [FW-1:0] LANES_F   = FW'(OUT_LANES);
    localparam logic [FW-1:0] START_F   = FW'(START_LVL);
    localparam logic [FW-1:0] NORM_F    = FW'(BITS_NORMAL);
    localparam logic [FW-1:0] TERM_F    = FW'(BITS_TERM * TERM_SYMS);
    localparam logic [FW-1:0] TAIL_STEP = FW'(2);
    localparam logic [FW-1:0] TAIL_LAST = FW'(2 + 2 * TERM_SYMS);
    localparam logic [PW-1:0] NORM_P    = PW'(BITS_NORMAL);
    localparam logic [PW-1:0] TWO_T_P   = PW'(2 * TERM_SYMS);
    localparam logic [PW-1:0] WR_TAIL_P = PW'(BITS_TERM * TERM_SYMS);
    localparam logic [KW-1:0] K_LAST    = KW'(TERM_SYMS - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD - 1);

    state_e                 state_q, state_d;
    logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [FW-1:0]          fill_q, fill_d, free_w, added_w, removed_w;
    logic [KW-1:0]          tail_k_q, tail_k_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [OUT_LANES-1:0]   out_q, out_d, rd_data_w;
    logic                   out_valid_q, out_valid_d, drop_q;
    logic                   acc_w, tail_sym_w, release_w, can_load_w, load_w;
    logic [PW-1:0]          k2_w, a0_w, a1_w, a2_w, a3_w;
    logic [3:0]             wr_en_w;

    assign free_w = DEPTH_F - fill_q;

    // Once a tail sequence has started its full 4T footprint is already reserved.
    always_comb begin
        in_ready = 1'b0;
        if (!reset && state_q != ST_DRAIN) begin
            if (tail_k_q != '0) begin
                in_ready = 1'b1;
            end else if (mode == MODE_NORMAL) begin
                in_ready = (free_w >= NORM_F);
            end else begin
                in_ready = (free_w >= TERM_F);
            end
        end
    end

    assign acc_w      = in_valid & in_ready;
    assign tail_sym_w = acc_w & ((tail_k_q != '0) | (mode == MODE_TERM));

    // wr_q stays at the tail base b until the whole sequence is committed.
    assign k2_w = PW'(tail_k_q) << 1;
    assign a0_w = tail_sym_w ? (wr_q + k2_w)                      : wr_q;
    assign a1_w = tail_sym_w ? (wr_q + k2_w + PW'(1))             : (wr_q + PW'(1));
    assign a2_w = tail_sym_w ? (wr_q + TWO_T_P + k2_w)            : (wr_q + PW'(2));
    assign a3_w = tail_sym_w ? (wr_q + TWO_T_P + k2_w + PW'(1))   : (wr_q + PW'(3));
    assign wr_en_w = !acc_w ? 4'b0000 : (tail_sym_w ? 4'b1111 : 4'b0111);

    bit_ring_store #(
        .DEPTH     (DEPTH),
        .OUT_LANES (OUT_LANES),
        .PW        (PW)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .wr_addr_i ({a3_w, a2_w, a1_w, a0_w}),
        .wr_en_i   (wr_en_w),
        .wr_data_i (in[3:0]),
        .rd_addr_i (rd_q),
        .rd_data_o (rd_data_w)
    );

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        tail_k_d     = tail_k_q;
        flush_pend_d = flush_pend_q;
        hold_d       = hold_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        added_w      = '0;
        removed_w    = '0;
        load_w       = 1'b0;
        release_w    = out_valid_q && (hold_q == '0) && out_ready;
        can_load_w   = !out_valid_q || release_w;

        if (acc_w) begin
            if (tail_sym_w) begin
                if (tail_k_q == K_LAST) begin
                    added_w  = TAIL_LAST;
                    tail_k_d = '0;
                    wr_d     = wr_q + WR_TAIL_P;
                end else begin
                    added_w  = TAIL_STEP;
                    tail_k_d = tail_k_q + KW'(1);
                end
            end else begin
                added_w = NORM_F;
                wr_d    = wr_q + NORM_P;
            end
        end

        if (out_valid_q && hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end
        if (release_w) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (fill_q >= START_F && fill_q >= LANES_F) begin
                    load_w  = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                load_w = can_load_w && (fill_q >= LANES_F);
            end
            ST_DRAIN: begin
                if (can_load_w && fill_q != '0) begin
                    load_w = 1'b1;
                end else if (fill_q == '0 && !out_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A short final word in DRAIN takes what is left and zero-pads the rest.
        if (load_w) begin
            removed_w   = (fill_q < LANES_F) ? fill_q : LANES_F;
            out_valid_d = 1'b1;
            hold_d      = HOLD_INIT;
            rd_d        = rd_q + removed_w[PW-1:0];
            for (int i = 0; i < OUT_LANES; i++) begin
                out_d[i] = (FW'(i) < removed_w) ? rd_data_w[i] : 1'b0;
            end
        end

        if (state_q != ST_DRAIN && (flush || flush_pend_q)) begin
            if (tail_k_d == '0) begin
                state_d      = ST_DRAIN;
                flush_pend_d = 1'b0;
            end else begin
                flush_pend_d = 1'b1;
            end
        end
    end

    assign fill_d = fill_q + added_w - removed_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_q         <= '0;
            rd_q         <= '0;
            fill_q       <= '0;
            tail_k_q     <= '0;
            hold_q       <= '0;
            flush_pend_q <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            fill_q       <= fill_d;
            tail_k_q     <= tail_k_d;
            hold_q       <= hold_d;
            flush_pend_q <= flush_pend_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            drop_q       <= in_valid & ~in_ready;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign drop      = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_turbo_out_buffer.sv
`default_nettype none
// ============================================================================
// tb_turbo_out_buffer : directed and random stimulus against a bit-queue
//                       reference model of the output buffer.
// Revision            : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_turbo_out_buffer;

    localparam int IN_W      = 4;
    localparam int OUT_LANES = 2;
    localparam int DEPTH     = 32;
    localparam int TERM_SYMS = 3;
    localparam int HOLD      = 8;
    localparam int START_LVL = 6;

    logic                 clk = 1'b0;
    logic                 reset, mode, in_valid, flush, out_ready;
    logic [IN_W-1:0]      in;
    logic                 in_ready, out_valid, drop;
    logic [OUT_LANES-1:0] out;

    always #5 clk = ~clk;

    turbo_out_buffer #(
        .IN_W      (IN_W),
        .OUT_LANES (OUT_LANES),
        .DEPTH     (DEPTH),
        .TERM_SYMS (TERM_SYMS),
        .HOLD      (HOLD),
        .START_LVL (START_LVL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop      (drop)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: committed bits kept in stream order in a queue.
    int                   mq[$];
    int                   mstash[$];
    int                   mtk, mst, mhc;
    bit                   mfp, mov, mdrop;
    logic [OUT_LANES-1:0] mow;

    task automatic m_reset();
        mq.delete();
        mstash.delete();
        mtk = 0; mst = 0; mhc = 0;
        mfp = 0; mov = 0; mdrop = 0;
        mow = '0;
    endtask

    function automatic bit m_ready(input logic md, input logic rst);
        if (rst) return 1'b0;
        if (mst == 2) return 1'b0;
        if (mtk > 0) return 1'b1;
        if (md == 1'b0) return (DEPTH - mq.size()) >= 3;
        return (DEPTH - mq.size()) >= 4 * TERM_SYMS;
    endfunction

    task automatic m_step();
        bit rdy, acc, rel, canl, ld, old_ov;
        int f, n, old_st, b;
        rdy    = m_ready(mode, 1'b0);
        acc    = in_valid && rdy;
        f      = mq.size();
        old_st = mst;
        old_ov = mov;
        rel    = mov && (mhc == 0) && out_ready;
        canl   = !mov || rel;
        case (mst)
            0:       ld = (f >= START_LVL) && (f >= OUT_LANES);
            1:       ld = canl && (f >= OUT_LANES);
            default: ld = canl && (f > 0);
        endcase
        if (ld) begin
            n = (f < OUT_LANES) ? f : OUT_LANES;
            for (int i = 0; i < OUT_LANES; i++) begin
                if (i < n) begin
                    b = mq.pop_front();
                    mow[i] = b[0];
                end else begin
                    mow[i] = 1'b0;
                end
            end
            mov = 1;
            mhc = HOLD - 1;
            if (mst == 0) mst = 1;
        end else begin
            if (rel) mov = 0;
            else if (mhc > 0) mhc--;
            if (mst == 2 && f == 0 && !old_ov) mst = 0;
        end
        if (acc) begin
            if (mtk > 0 || mode) begin
                mq.push_back(int'(in[0]));
                mq.push_back(int'(in[1]));
                mstash.push_back(int'(in[2]));
                mstash.push_back(int'(in[3]));
                mtk++;
                if (mtk == TERM_SYMS) begin
                    foreach (mstash[j]) mq.push_back(mstash[j]);
                    mstash.delete();
                    mtk = 0;
                end
            end else begin
                mq.push_back(int'(in[0]));
                mq.push_back(int'(in[1]));
                mq.push_back(int'(in[2]));
            end
        end
        if (old_st != 2 && (flush || mfp)) begin
            if (mtk == 0) begin
                mst = 2;
                mfp = 0;
            end else begin
                mfp = 1;
            end
        end
        mdrop = in_valid && !rdy;
    endtask

    // One clock: drive at the falling edge, compare, then advance the model.
    task automatic cyc(input logic v, input logic md, input logic [3:0] d,
                       input logic fl, input logic ordy);
        in_valid  = v;
        mode      = md;
        in        = d;
        flush     = fl;
        out_ready = ordy;
        #1;
        check_val("in_ready", in_ready, m_ready(md, reset));
        check_val("out_valid", out_valid, mov);
        check_val("out", out, mow);
        check_val("drop", drop, mdrop);
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        m_reset();
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out", out, 0);
        check_val("rst_drop", drop, 0);
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic rand_cyc(input int p_valid, input int p_ordy, input int p_flush, input int p_mode);
        cyc($urandom_range(99) < p_valid, $urandom_range(99) < p_mode, 4'($urandom),
            $urandom_range(999) < p_flush, $urandom_range(99) < p_ordy);
    endtask

    initial begin
        reset = 1'b0; mode = 1'b0; in = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        m_reset();
        #2;
        do_reset(2);

        // Four normal symbols, consumer always ready.
        cyc(1, 0, 4'b0101, 0, 1);
        cyc(1, 0, 4'b0010, 0, 1);
        cyc(1, 0, 4'b0111, 0, 1);
        check_val("first_word_valid", out_valid, 1);
        check_val("first_word", out, 2'b01);
        cyc(1, 0, 4'b0000, 0, 1);
        repeat (40) cyc(0, 0, 4'b0000, 0, 1);

        // Tail sequence; mode drops mid-sequence but the sequence still completes.
        cyc(1, 1, 4'b1101, 0, 1);
        cyc(1, 0, 4'b0110, 0, 1);
        cyc(1, 1, 4'b1011, 0, 1);
        repeat (80) cyc(0, 0, 4'b0000, 0, 1);

        // Fill up with the consumer stalled, then try a tail start.
        repeat (14) cyc(1, 0, 4'($urandom), 0, 0);
        repeat (4) cyc(1, 1, 4'($urandom), 0, 0);
        repeat (25) cyc(0, 0, 4'b0000, 0, 0);
        repeat (160) cyc(0, 0, 4'b0000, 0, 1);

        // Seven committed bits, then flush.
        do_reset(1);
        cyc(1, 0, 4'b0110, 0, 0);
        cyc(1, 0, 4'b0101, 0, 0);
        cyc(1, 0, 4'b0011, 0, 0);
        cyc(0, 0, 4'b0000, 1, 1);
        repeat (3) cyc(1, 0, 4'b0001, 0, 1);
        repeat (60) cyc(0, 0, 4'b0000, 0, 1);
        check_val("flush_idle_valid", out_valid, 0);

        // Flush during a tail sequence waits for the sequence to finish.
        cyc(1, 1, 4'b1001, 0, 1);
        cyc(1, 1, 4'b0110, 1, 1);
        cyc(1, 0, 4'b1111, 0, 1);
        repeat (70) cyc(0, 0, 4'b0000, 0, 1);

        // Reset in the middle of a tail sequence.
        cyc(1, 1, 4'b1101, 0, 1);
        do_reset(2);
        cyc(1, 0, 4'b0111, 0, 1);
        cyc(1, 0, 4'b0001, 0, 1);
        repeat (30) cyc(0, 0, 4'b0000, 0, 1);

        for (int ph = 0; ph < 6; ph++) begin
            repeat (600) rand_cyc(60, ph * 20, 6, 30);
            if (ph == 3) do_reset(1);
        end
        repeat (300) cyc(0, 0, 4'b0000, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/turbo_out_buffer.md
# turbo_out_buffer

Parametrised output rate-matching buffer at the tail of the turbo encoder datapath. It accepts encoder symbols (x, z, z', x') through a valid/ready handshake and packs them into a circular bit store. Tail symbols are reordered into trellis-termination order. The block emits OUT_LANES-bit words, each held for a programmable minimum number of cycles, under a valid/ready handshake.

## Interface
- IN_W, 4: bits per input symbol. in[0]=x, in[1]=z, in[2]=z', in[3]=x'.
- OUT_LANES, 2: bits per output word.
- DEPTH, 32: bit-store depth. Power of 2, ≥ 4*TERM_SYMS + OUT_LANES.
- TERM_SYMS, 3: symbols in one termination (tail) sequence.
- HOLD, 8: minimum cycles each output word is held (≥1).
- START_LVL, 6: committed bits required before streaming starts.
- clk  in  1  clock. One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  0 = normal (3 bits/symbol), 1 = termination (4 bits/symbol, reordered).
- in  in  IN_W  input symbol.
- in_valid  in  1  symbol present.
- in_ready  out  1  symbol accepted on a clk edge with in_valid=1. Combinational; forced 0 while reset is high.
- flush  in  1  pulse: drain all committed bits, then return to IDLE.
- out  out  OUT_LANES  output word. out[i] = store[rd+i].
- out_valid  out  1  word present.
- out_ready  in  1  consumer accepts the word.
- drop  out  1  one-cycle pulse when in_valid=1 and in_ready=0.

## Operation
- Reset values: out=0, out_valid=0, drop=0, wr=rd=0, fill=0, hold_cnt=0, state IDLE, tail_k=0, flush_pend=0.
- Normal symbol (mode=0 on acceptance): in[0..2] → store[wr..wr+2]; wr += 3; fill += 3.
- Tail sequence: starts when a symbol is accepted with mode=1 and tail_k=0. The sequence completes all TERM_SYMS symbols regardless of later mode. For base b and tail_k=k:
  - in[0] → b+2k, in[1] → b+2k+1.
  - in[2] → b+2T+2k, in[3] → b+2T+2k+1, where T=TERM_SYMS.
  - fill += 2 per tail symbol. The last tail symbol adds a further 2T.
  - wr = b+4T after the sequence.
- Fill counts only contiguous committed bits, so the reader never passes unwritten B-region bits.
- in_ready rules:
  - 0 in DRAIN.
  - Mid-tail (tail_k>0): 1, because space is reserved.
  - Else mode=0: DEPTH−fill ≥ 3.
  - Else mode=1: DEPTH−fill ≥ 4T.
- States:
  - IDLE → STREAM when fill ≥ START_LVL. The first word loads on that edge.
  - STREAM: when no word is held and fill ≥ OUT_LANES, load out, rd += OUT_LANES, out_valid=1, hold_cnt=HOLD−1.
  - Word release: on an edge with hold_cnt=0 and out_ready=1. The next word loads on the same edge if available; otherwise out_valid drops to 0 and the state stays STREAM.
  - STREAM/IDLE → DRAIN on flush (latched as flush_pend). If a tail sequence is in progress, flush waits until it completes.
  - DRAIN: emit words while fill > 0. A final partial word is zero-padded in the upper lanes.
  - DRAIN → IDLE when fill=0 and no word is held.
- Arithmetic:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - fill is log2(DEPTH)+1 bits.
  - Same-edge update: fill' = fill + added − removed.
- Reset asserted mid-operation clears everything immediately, including any partial tail sequence and pending flush.

## Timing
- Symbol accepted on edge t reaching START_LVL → out_valid=1 after edge t+1.
- A held word is stable for at least HOLD cycles. With out_ready tied 1 and no underflow, a new word appears every HOLD cycles.
- drop is registered and asserted the cycle after the refused attempt.
- Simultaneous write and read: both take effect, and fill nets them.
- Full: in_ready=0; the store is never overwritten.
- Empty in STREAM: out_valid=0 until fill ≥ OUT_LANES.

## Structure
- Package turbo_out_pkg: state enum (IDLE, STREAM, DRAIN), mode constants, bits-per-symbol constants (3, 4), pointer-width function.
- Sub-module bit_ring_store: DEPTH-bit register array. Provides a 4-bit scattered write (per-bit address and enable) and an OUT_LANES-bit contiguous read at rd.
- Top level holds the FSM, pointers, fill, tail sequencer and hold counter.

## Test plan
- Defaults, 4 normal symbols (in=4'b0101, 4'b0010, 4'b0111, 4'b0000), out_ready=1:
  - First out_valid one cycle after the second symbol.
  - Words {z,x} in stream order, each held exactly 8 cycles.
- Tail sequence, 3 symbols with mode=1 (in = 4'b1101, 4'b0110, 4'b1011):
  - Store order = x0 z0 x1 z1 x2 z2 z'0 x'0 z'1 x'1 z'2 x'2.
  - fill steps 2, 4, 12.
- Fill to 30 bits with out_ready=0:
  - normal symbol → in_ready=0 and drop pulses;
  - tail start → in_ready=0 at fill ≥ 21.
- 7 committed bits, then flush:
  - words emitted: 3 full plus 1 padded {0, b6};
  - in_ready=0 throughout;
  - returns to IDLE with fill=0.
- out_ready held 0 for 20 cycles:
  - out unchanged and out_valid=1;
  - release on the first edge with out_ready=1.
- Reset asserted midway through a tail sequence (tail_k=1):
  - all outputs 0, in_ready=0 during reset;
  - after release, a normal symbol is written at address 0.
